// File: rtl/dmux_stream_1ton_if.sv
// Handshake bundle for the registered 1-to-N stream demultiplexer.
// master = producer/consumer side, slave = the demultiplexer itself.
interface dmux_stream_1ton_if #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic [N_CH-1:0]         out_valid;
  logic [N_CH-1:0]         out_ready;
  logic [N_CH*WIDTH-1:0]   out_data;
  logic                    drop;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, drop
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, drop
  );
endinterface

// File: rtl/dmux_stream_1ton.sv
// Registered 1-to-N valid/ready demultiplexer with unicast, broadcast and
// out-of-range drop; each channel owns a one-entry holding register.
module dmux_stream_1ton #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmux_stream_1ton_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]             valid_q, valid_d;
  logic [N_CH-1:0][WIDTH-1:0]  data_q, data_d;
  logic                        drop_q, drop_d;

  logic [N_CH-1:0]             free_s;
  logic [N_CH-1:0]             sel_oh_s;
  logic [N_CH-1:0]             load_s;
  logic                        ready_s;
  logic                        xfer_s;

  // Channel freedom, acceptance decision and next-state of every holding register.
  always_comb begin
    free_s   = '0;
    sel_oh_s = '0;
    load_s   = '0;
    ready_s  = 1'b1;
    valid_d  = valid_q;
    data_d   = data_q;

    for (int i = 0; i < N_CH; i++) begin
      free_s[i]   = ~valid_q[i] | bus.out_ready[i];
      sel_oh_s[i] = (bus.in_sel == SEL_W'(i));
    end

    // An out-of-range select hits no channel and is always accepted.
    if (bus.in_bcast) begin
      ready_s = &free_s;
    end else if (|sel_oh_s) begin
      ready_s = |(sel_oh_s & free_s);
    end else begin
      ready_s = 1'b1;
    end

    xfer_s = bus.in_valid & ready_s;

    if (xfer_s && bus.in_bcast) begin
      load_s = '1;
    end else if (xfer_s) begin
      load_s = sel_oh_s;
    end else begin
      load_s = '0;
    end

    drop_d = xfer_s & ~bus.in_bcast & ~(|sel_oh_s);

    for (int i = 0; i < N_CH; i++) begin
      if (load_s[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end else begin
        valid_d[i] = valid_q[i] & ~bus.out_ready[i];
        data_d[i]  = data_q[i];
      end
    end
  end

  // State registers; data is kept after draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.drop      = drop_q;
endmodule

// File: tb/tb_dmux_stream_1ton.sv
// Directed bench for dmux_stream_1ton: a 4-channel vector table plus
// hand-written streaming, out-of-range drop (3 channels) and async reset checks.
module tb_dmux_stream_1ton;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmux_stream_1ton_if #(.WIDTH(16), .N_CH(4)) bus4 ();
  dmux_stream_1ton_if #(.WIDTH(16), .N_CH(3)) bus3 ();

  dmux_stream_1ton #(.WIDTH(16), .N_CH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  dmux_stream_1ton #(.WIDTH(16), .N_CH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        bc;
    logic [15:0] d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    int          ch;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic v, input logic [1:0] sel, input logic bc,
                        input logic [15:0] d, input logic [3:0] ordy);
    bus4.in_valid  = v;
    bus4.in_sel    = sel;
    bus4.in_bcast  = bc;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          v     sel   bc    data      ordy     rdy   vld_after ch exp_data
    vec[0]  = '{1'b1, 2'd2, 1'b0, 16'hA5A5, 4'b1111, 1'b1, 4'b0100, 2, 16'hA5A5};
    vec[1]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 2, 16'hA5A5};
    vec[2]  = '{1'b1, 2'd1, 1'b0, 16'h0001, 4'b1101, 1'b1, 4'b0010, 1, 16'h0001};
    vec[3]  = '{1'b1, 2'd1, 1'b0, 16'h0002, 4'b1101, 1'b0, 4'b0010, 1, 16'h0001};
    vec[4]  = '{1'b1, 2'd3, 1'b0, 16'h0003, 4'b0101, 1'b1, 4'b1010, 3, 16'h0003};
    vec[5]  = '{1'b1, 2'd1, 1'b0, 16'h0002, 4'b0111, 1'b1, 4'b1010, 1, 16'h0002};
    vec[6]  = '{1'b1, 2'd0, 1'b0, 16'h0010, 4'b1110, 1'b1, 4'b0001, 0, 16'h0010};
    vec[7]  = '{1'b1, 2'd0, 1'b1, 16'hBEEF, 4'b1110, 1'b0, 4'b0001, 0, 16'h0010};
    vec[8]  = '{1'b1, 2'd0, 1'b1, 16'hBEEF, 4'b1111, 1'b1, 4'b1111, 1, 16'hBEEF};
    vec[9]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b1111, 3, 16'hBEEF};
    vec[10] = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 0, 16'hBEEF};

    rst = 1'b1;
    drive4(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111);
    bus3.in_valid  = 1'b0;
    bus3.in_sel    = 2'd0;
    bus3.in_bcast  = 1'b0;
    bus3.in_data   = 16'h0000;
    bus3.out_ready = 3'b111;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(bus4.out_valid), 64'h0);
    chk("reset_out_data",  64'(bus4.out_data),  64'h0);
    chk("reset_drop",      64'(bus4.drop),      64'h0);
    chk("reset_in_ready",  64'(bus4.in_ready),  64'h1);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive4(vec[k].v, vec[k].sel, vec[k].bc, vec[k].d, vec[k].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", k), 64'(bus4.in_ready), 64'(vec[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", k), 64'(bus4.out_valid), 64'(vec[k].exp_vld));
      chk($sformatf("vec%0d_out_data", k), 64'(bus4.out_data[vec[k].ch*16 +: 16]), 64'(vec[k].exp_d));
      chk($sformatf("vec%0d_drop", k), 64'(bus4.drop), 64'h0);
    end

    // Streaming: one word per cycle into ch0, no gaps.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive4(1'b1, 2'd0, 1'b0, 16'(k), 4'b1111);
      #1;
      chk($sformatf("stream%0d_in_ready", k), 64'(bus4.in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_valid", k), 64'(bus4.out_valid), 64'h1);
      chk($sformatf("stream%0d_data", k), 64'(bus4.out_data[15:0]), 64'(k));
    end
    @(negedge clk);
    drive4(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111);
    @(posedge clk);
    #1;
    chk("stream_end_valid", 64'(bus4.out_valid), 64'h0);

    // Three-channel instance: park a word on ch1, then send to index 3.
    @(negedge clk);
    bus3.in_valid  = 1'b1;
    bus3.in_sel    = 2'd1;
    bus3.in_data   = 16'h0055;
    bus3.out_ready = 3'b000;
    @(posedge clk);
    #1;
    chk("n3_load_valid", 64'(bus3.out_valid), 64'h2);
    @(negedge clk);
    bus3.in_sel  = 2'd3;
    bus3.in_data = 16'h7777;
    #1;
    chk("n3_oor_in_ready", 64'(bus3.in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("n3_oor_drop", 64'(bus3.drop), 64'h1);
    chk("n3_oor_valid", 64'(bus3.out_valid), 64'h2);
    chk("n3_oor_data", 64'(bus3.out_data), {16'h0, 16'h0, 16'h0055, 16'h0});
    @(negedge clk);
    bus3.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("n3_drop_cleared", 64'(bus3.drop), 64'h0);
    chk("n3_valid_kept", 64'(bus3.out_valid), 64'h2);

    // Async reset with ch2 held, asserted between clock edges.
    @(negedge clk);
    drive4(1'b1, 2'd2, 1'b0, 16'hC3C3, 4'b0000);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(bus4.out_valid), 64'h4);
    drive4(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus4.out_valid), 64'h0);
    chk("async_rst_data",  64'(bus4.out_data),  64'h0);
    chk("async_rst_n3_valid", 64'(bus3.out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive4(1'b1, 2'd3, 1'b0, 16'h1234, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(bus4.out_valid), 64'h8);
    chk("post_rst_data",  64'(bus4.out_data[63:48]), 64'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmux_stream_1ton.md
Name: dmux_stream_1toN

Overview:
- Parametrised, registered 1-to-N demultiplexer for the 16-bit CPU datapath; successor to the 2-output combinational dmux.
- Routes a WIDTH-bit word from one valid/ready input stream to one of N_CH output streams, selected per transfer, or to all N_CH outputs in broadcast mode.
- Each output has a one-entry holding register, so a stalled consumer blocks only transfers addressed to it.
- Sits between the instruction/ALU result path and multiple consumers (register file, memory write port, I/O).

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- N_CH, 4, number of output channels (2..16).
- SEL_W, (N_CH>1 ? $clog2(N_CH) : 1), select width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index, valid with in_valid.
- in_bcast  input  1  1 = write all channels; in_sel ignored.
- out_valid  output  N_CH  per-channel word present.
- out_ready  input  N_CH  per-channel consumer accepts.
- out_data  output  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- drop  output  1  one-cycle pulse: accepted word had in_sel >= N_CH and was discarded.

Behaviour:
- Reset: on rst high, immediately and asynchronously clear out_valid to all 0, all out_data to 0, drop to 0. Any held word is lost. in_ready follows from the cleared state.
- Channel i is free when !out_valid[i] || out_ready[i]. Same-cycle drain and refill is allowed, giving full throughput per channel.
- in_ready is combinational:
  - in_bcast=1: AND of free[i] over all channels.
  - in_bcast=0 and in_sel < N_CH: free[in_sel].
  - in_sel >= N_CH: 1.
- in_ready never depends on in_valid. A combinational path from out_ready to in_ready is permitted.
- A transfer occurs when in_valid && in_ready at a clock edge.
- Unicast transfer: out_data[in_sel] <= in_data and out_valid[in_sel] <= 1 at that edge. Latency is 1 cycle to out_valid.
- Broadcast transfer: every channel loads in_data and sets out_valid.
- Out-of-range transfer (in_sel >= N_CH, in_bcast=0): no channel changes; drop <= 1 for exactly the next cycle. Only possible when N_CH is not a power of 2.
- Output handshake: a word leaves channel i at an edge where out_valid[i] && out_ready[i].
  - If there is no simultaneous refill of that channel, out_valid[i] <= 0.
  - out_data[i] holds its value while out_valid[i]=1 and out_ready[i]=0.
  - out_data[i] keeps its last value after draining (no clear).
- Simultaneous drain and refill on the same channel: new word is loaded and out_valid stays 1; no bubble, no loss.
- Channels are independent: a stall on channel j never blocks a unicast to channel k != j. A broadcast waits until all channels are free.
- in_sel and in_bcast are sampled only on transfer cycles; their value is don't-care when in_valid=0.
- drop is 0 in every cycle not immediately following an out-of-range transfer.
- No internal FSM beyond the per-channel valid bits. Total storage is N_CH*(WIDTH+1)+1 flops.

Test Plan:
- Reset, then release rst; N_CH=4, out_ready=4'b1111, in_data=16'hA5A5, sel=2, one cycle -> next cycle out_valid=4'b0100, out_data ch2=16'hA5A5, in_ready=1 throughout.
- Back-pressure: out_ready[1]=0, send 16'h0001 then 16'h0002 to sel=1 -> first held on ch1, in_ready=0 for sel=1 while a send to sel=3 with 16'h0003 is accepted; raise out_ready[1] -> 16'h0002 loads in the same edge ch1 drains (out_valid[1] stays 1).
- Broadcast 16'hBEEF with out_ready[0]=0 and ch0 full -> in_ready=0 until out_ready[0]=1; then all four channels show 16'hBEEF and out_valid=4'b1111 one cycle later.
- N_CH=3 instance: in_sel=3, in_valid=1 -> accepted (in_ready=1), out_valid unchanged, drop=1 for exactly one cycle.
- Streaming: 16 consecutive words 16'h0000..16'h000F to sel=0 with out_ready[0]=1 -> one word per cycle, in order, no gaps.
- Assert rst asynchronously mid-stream with ch2 full -> out_valid=0 and out_data=0 immediately, before the next clk edge; traffic resumes correctly after release.
